// File: rtl/ball_pkg.sv
// Shared constants, pair lookup tables and types for the ball collision detector.
package ball_pkg;

    localparam int unsigned NUM_BALLS    = 5;
    localparam int unsigned NUM_PAIRS    = 10;
    localparam int unsigned COORD_W      = 32;
    localparam int unsigned COORD_DIFF_W = 12;
    localparam int unsigned PAIR_IDX_W   = 4;
    localparam int unsigned BALL_IDX_W   = 3;

    typedef logic [BALL_IDX_W-1:0]          ballIdx_t;
    typedef logic [PAIR_IDX_W-1:0]          pairIdx_t;
    typedef logic signed [COORD_W-1:0]      coord_t;
    typedef logic signed [COORD_DIFF_W-1:0] coordDiff_t;

    typedef enum logic [2:0] {IDLE, SNAP, CALC, DRAIN, DONE} colDetState_t;

    // Scan order: (0,1) (0,2) (0,3) (0,4) (1,2) (1,3) (1,4) (2,3) (2,4) (3,4)
    localparam ballIdx_t PAIR_I [NUM_PAIRS] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                                                3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
    localparam ballIdx_t PAIR_J [NUM_PAIRS] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2,
                                                3'd3, 3'd4, 3'd3, 3'd4, 3'd4};

    // 32-bit signed difference clamped to +/-sat, narrowed to the pipeline width.
    function automatic coordDiff_t satDiff(input coord_t a, input coord_t b,
                                           input int unsigned sat);
        coord_t     d;
        coord_t     lim;
        coordDiff_t r;
        d   = a - b;
        lim = $signed(32'(sat));
        if (d > lim)
            r = coordDiff_t'(lim);
        else if (d < -lim)
            r = coordDiff_t'(-lim);
        else
            r = coordDiff_t'(d);
        return r;
    endfunction

endpackage

// File: rtl/pair_dist_sq.sv
// Two-stage pipeline: saturated coordinate differences, then squared distance vs threshold.
// COL_APPROACH_ONLY_EN adds a relative-velocity dot product so only approaching pairs hit.
module pair_dist_sq
    import ball_pkg::*;
#(
    parameter int unsigned BALL_DIAMETER = 32,
    parameter int unsigned COORD_SAT     = 2047
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       issueValid,
    input  pairIdx_t   issueTag,
    input  logic       pairActive,
    input  coord_t     xI,
    input  coord_t     xJ,
    input  coord_t     yI,
    input  coord_t     yJ,
`ifdef COL_APPROACH_ONLY_EN
    input  coord_t     vxI,
    input  coord_t     vxJ,
    input  coord_t     vyI,
    input  coord_t     vyJ,
`endif
    output logic       hitValid_c,
    output pairIdx_t   hitTag_c,
    output logic       hit_c
);

    localparam int unsigned SQ_W  = 2 * COORD_DIFF_W;
    localparam int unsigned D2_W  = 2 * COORD_DIFF_W - 1;
    localparam logic [D2_W-1:0] THRESH = D2_W'(BALL_DIAMETER * BALL_DIAMETER);

    logic       validA;
    pairIdx_t   tagA;
    logic       activeA;
    coordDiff_t dxA;
    coordDiff_t dyA;

    logic signed [SQ_W-1:0] dxSq_c;
    logic signed [SQ_W-1:0] dySq_c;
    logic [D2_W-1:0]        d2_c;
    logic                   approach_c;

`ifdef COL_APPROACH_ONLY_EN
    localparam int unsigned DOT_W = 2 * COORD_DIFF_W + 1;
    coordDiff_t             dvxA;
    coordDiff_t             dvyA;
    logic signed [DOT_W-1:0] dot_c;
`endif

    // Stage A: register the saturated differences with their pair tag.
    always_ff @(posedge clk) begin
        if (resetN) begin
            validA  <= 1'b0;
            tagA    <= '0;
            activeA <= 1'b0;
            dxA     <= '0;
            dyA     <= '0;
`ifdef COL_APPROACH_ONLY_EN
            dvxA    <= '0;
            dvyA    <= '0;
`endif
        end else begin
            validA <= issueValid;
            if (issueValid) begin
                tagA    <= issueTag;
                activeA <= pairActive;
                dxA     <= satDiff(xI, xJ, COORD_SAT);
                dyA     <= satDiff(yI, yJ, COORD_SAT);
`ifdef COL_APPROACH_ONLY_EN
                dvxA    <= satDiff(vxI, vxJ, COORD_SAT);
                dvyA    <= satDiff(vyI, vyJ, COORD_SAT);
`endif
            end
        end
    end

    // Stage B: squared distance and hit decision; the caller's shadow bit is the stage register.
    always_comb begin
        dxSq_c = SQ_W'(dxA) * SQ_W'(dxA);
        dySq_c = SQ_W'(dyA) * SQ_W'(dyA);
        d2_c   = D2_W'(dxSq_c) + D2_W'(dySq_c);
`ifdef COL_APPROACH_ONLY_EN
        dot_c      = DOT_W'(dxA) * DOT_W'(dvxA) + DOT_W'(dyA) * DOT_W'(dvyA);
        approach_c = dot_c[DOT_W-1];
`else
        approach_c = 1'b1;
`endif
        hitValid_c = validA;
        hitTag_c   = tagA;
        hit_c      = validA && activeA && (d2_c < THRESH) && approach_c;
    end

endmodule

// File: rtl/ball_collision_detect.sv
// Per-frame pairwise overlap scan of 5 balls; publishes col01..col34 levels with a colValid pulse.
// COL_APPROACH_ONLY_EN restricts hits to pairs whose relative velocity closes the gap.
module ball_collision_detect
    import ball_pkg::*;
#(
    parameter int unsigned BALL_DIAMETER = 32,
    parameter int unsigned COORD_SAT     = 2047
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS-1:0] ballActive,
    input  logic signed [31:0]   topLeftX0,
    input  logic signed [31:0]   topLeftX1,
    input  logic signed [31:0]   topLeftX2,
    input  logic signed [31:0]   topLeftX3,
    input  logic signed [31:0]   topLeftX4,
    input  logic signed [31:0]   topLeftY0,
    input  logic signed [31:0]   topLeftY1,
    input  logic signed [31:0]   topLeftY2,
    input  logic signed [31:0]   topLeftY3,
    input  logic signed [31:0]   topLeftY4,
    input  logic signed [31:0]   xSpeed0,
    input  logic signed [31:0]   xSpeed1,
    input  logic signed [31:0]   xSpeed2,
    input  logic signed [31:0]   xSpeed3,
    input  logic signed [31:0]   xSpeed4,
    input  logic signed [31:0]   ySpeed0,
    input  logic signed [31:0]   ySpeed1,
    input  logic signed [31:0]   ySpeed2,
    input  logic signed [31:0]   ySpeed3,
    input  logic signed [31:0]   ySpeed4,
    output logic                 col01,
    output logic                 col02,
    output logic                 col03,
    output logic                 col04,
    output logic                 col12,
    output logic                 col13,
    output logic                 col14,
    output logic                 col23,
    output logic                 col24,
    output logic                 col34,
    output logic                 colValid,
    output logic                 busy
);

    colDetState_t         state;
    colDetState_t         stateNext;
    logic                 sofQ;
    pairIdx_t             pairIdx;
    logic [NUM_PAIRS-1:0] shadow;
    logic [NUM_PAIRS-1:0] colVec;

    logic snap_c;
    logic issue_c;
    logic publish_c;
    logic busyNext_c;

    coord_t               snapX [NUM_BALLS];
    coord_t               snapY [NUM_BALLS];
    logic [NUM_BALLS-1:0] snapActive;

    ballIdx_t idxI_c;
    ballIdx_t idxJ_c;
    logic     pairActive_c;
    logic     hitValid_c;
    pairIdx_t hitTag_c;
    logic     hit_c;

    // State register.
    always_ff @(posedge clk) begin
        if (resetN)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next state; a frame strobe in any non-idle state restarts the scan.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (sofQ) stateNext = SNAP;
            SNAP:    stateNext = CALC;
            CALC:    if (pairIdx == pairIdx_t'(NUM_PAIRS - 1)) stateNext = DRAIN;
            DRAIN:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (sofQ && (state != IDLE))
            stateNext = SNAP;
    end

    // Control decode.
    always_comb begin
        snap_c     = (state == SNAP);
        issue_c    = (state == CALC);
        publish_c  = (state == DONE) && !sofQ;
        busyNext_c = (stateNext != IDLE);
    end

    // Frame strobe, pair counter, shadow and published outputs.
    always_ff @(posedge clk) begin
        if (resetN) begin
            sofQ     <= 1'b0;
            busy     <= 1'b0;
            colValid <= 1'b0;
            colVec   <= '0;
            shadow   <= '0;
            pairIdx  <= '0;
        end else begin
            sofQ     <= startOfFrame;
            busy     <= busyNext_c;
            colValid <= publish_c;
            if (publish_c)
                colVec <= shadow;
            if (snap_c) begin
                shadow  <= '0;
                pairIdx <= '0;
            end else begin
                if (issue_c && (pairIdx != pairIdx_t'(NUM_PAIRS - 1)))
                    pairIdx <= pairIdx + pairIdx_t'(1);
                if (hitValid_c)
                    shadow[hitTag_c] <= hit_c;
            end
        end
    end

    // Frame snapshot of positions and activity.
    always_ff @(posedge clk) begin
        if (resetN) begin
            snapX      <= '{default: '0};
            snapY      <= '{default: '0};
            snapActive <= '0;
        end else if (snap_c) begin
            snapX      <= '{topLeftX0, topLeftX1, topLeftX2, topLeftX3, topLeftX4};
            snapY      <= '{topLeftY0, topLeftY1, topLeftY2, topLeftY3, topLeftY4};
            snapActive <= ballActive;
        end
    end

    always_comb begin
        idxI_c       = PAIR_I[pairIdx];
        idxJ_c       = PAIR_J[pairIdx];
        pairActive_c = snapActive[idxI_c] & snapActive[idxJ_c];
    end

`ifdef COL_APPROACH_ONLY_EN
    coord_t snapVx [NUM_BALLS];
    coord_t snapVy [NUM_BALLS];

    always_ff @(posedge clk) begin
        if (resetN) begin
            snapVx <= '{default: '0};
            snapVy <= '{default: '0};
        end else if (snap_c) begin
            snapVx <= '{xSpeed0, xSpeed1, xSpeed2, xSpeed3, xSpeed4};
            snapVy <= '{ySpeed0, ySpeed1, ySpeed2, ySpeed3, ySpeed4};
        end
    end
`else
    logic unusedSpeeds;
    assign unusedSpeeds = ^{xSpeed0, xSpeed1, xSpeed2, xSpeed3, xSpeed4,
                            ySpeed0, ySpeed1, ySpeed2, ySpeed3, ySpeed4};
`endif

    pair_dist_sq #(
        .BALL_DIAMETER (BALL_DIAMETER),
        .COORD_SAT     (COORD_SAT)
    ) uPairDist (
        .clk        (clk),
        .resetN     (resetN),
        .issueValid (issue_c),
        .issueTag   (pairIdx),
        .pairActive (pairActive_c),
        .xI         (snapX[idxI_c]),
        .xJ         (snapX[idxJ_c]),
        .yI         (snapY[idxI_c]),
        .yJ         (snapY[idxJ_c]),
`ifdef COL_APPROACH_ONLY_EN
        .vxI        (snapVx[idxI_c]),
        .vxJ        (snapVx[idxJ_c]),
        .vyI        (snapVy[idxI_c]),
        .vyJ        (snapVy[idxJ_c]),
`endif
        .hitValid_c (hitValid_c),
        .hitTag_c   (hitTag_c),
        .hit_c      (hit_c)
    );

    assign col01 = colVec[0];
    assign col02 = colVec[1];
    assign col03 = colVec[2];
    assign col04 = colVec[3];
    assign col12 = colVec[4];
    assign col13 = colVec[5];
    assign col14 = colVec[6];
    assign col23 = colVec[7];
    assign col24 = colVec[8];
    assign col34 = colVec[9];

endmodule

// File: tb/tb_ball_collision_detect.sv
// Self-checking bench for ball_collision_detect: directed geometry cases plus randomized
// frames checked against a pairwise-distance reference model.
module tb_ball_collision_detect;

    localparam int TB_DIAM = 32;
    localparam int TB_SAT  = 2047;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic [4:0] act;
    int         bx  [5];
    int         by  [5];
    int         bvx [5];
    int         bvy [5];

    logic col01, col02, col03, col04, col12, col13, col14, col23, col24, col34;
    logic colValid;
    logic busy;
    logic [9:0] colObs;

    int vectors;
    int miscompares;
    logic [9:0] prevCols;
    logic [9:0] expCols;
    int pulses;

    assign colObs = {col34, col24, col23, col14, col13, col12, col04, col03, col02, col01};

    ball_collision_detect dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .ballActive   (act),
        .topLeftX0    (bx[0]),
        .topLeftX1    (bx[1]),
        .topLeftX2    (bx[2]),
        .topLeftX3    (bx[3]),
        .topLeftX4    (bx[4]),
        .topLeftY0    (by[0]),
        .topLeftY1    (by[1]),
        .topLeftY2    (by[2]),
        .topLeftY3    (by[3]),
        .topLeftY4    (by[4]),
        .xSpeed0      (bvx[0]),
        .xSpeed1      (bvx[1]),
        .xSpeed2      (bvx[2]),
        .xSpeed3      (bvx[3]),
        .xSpeed4      (bvx[4]),
        .ySpeed0      (bvy[0]),
        .ySpeed1      (bvy[1]),
        .ySpeed2      (bvy[2]),
        .ySpeed3      (bvy[3]),
        .ySpeed4      (bvy[4]),
        .col01        (col01),
        .col02        (col02),
        .col03        (col03),
        .col04        (col04),
        .col12        (col12),
        .col13        (col13),
        .col14        (col14),
        .col23        (col23),
        .col24        (col24),
        .col34        (col34),
        .colValid     (colValid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat(input longint d);
        if (d > TB_SAT) return longint'(TB_SAT);
        if (d < -TB_SAT) return -longint'(TB_SAT);
        return d;
    endfunction

    // Every unordered pair in scan order; pair p lands in bit p.
    function automatic logic [9:0] modelCols();
        logic [9:0] r;
        longint dx, dy, d2;
        logic hit;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                dx  = sat(longint'(bx[i] - bx[j]));
                dy  = sat(longint'(by[i] - by[j]));
                d2  = dx * dx + dy * dy;
                hit = (d2 < longint'(TB_DIAM * TB_DIAM)) && act[3'(i)] && act[3'(j)];
`ifdef COL_APPROACH_ONLY_EN
                if (dx * sat(longint'(bvx[i] - bvx[j])) + dy * sat(longint'(bvy[i] - bvy[j])) >= 0)
                    hit = 1'b0;
`endif
                r = {hit, r[9:1]};
            end
        end
        return r;
    endfunction

    task automatic setFar();
        bx[0] = 100;  by[0] = 100;
        bx[1] = 1000; by[1] = 1000;
        bx[2] = 2000; by[2] = 100;
        bx[3] = 100;  by[3] = 2000;
        bx[4] = 3000; by[4] = 3000;
        for (int i = 0; i < 5; i++) begin
            bvx[i] = 0;
            bvy[i] = 0;
        end
        act = 5'b11111;
    endtask

    task automatic scrambleInputs();
        for (int i = 0; i < 5; i++) begin
            bx[i]  = int'($urandom_range(0, 60));
            by[i]  = int'($urandom_range(0, 60));
            bvx[i] = int'($urandom_range(0, 40)) - 20;
            bvy[i] = int'($urandom_range(0, 40)) - 20;
        end
        act = 5'($urandom);
    endtask

    // One full frame from the strobe through the colValid pulse.
    task automatic runFrame(input logic [9:0] exp, input bit scramble);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        checkEq("busy_e0", 32'(busy), 32'd0);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (scramble && e == 3) scrambleInputs();
            checkEq("busy_scan", 32'(busy), 32'd1);
            checkEq("colValid_scan", 32'(colValid), 32'd0);
            checkEq("col_hold", 32'(colObs), 32'(prevCols));
        end
        tick();
        checkEq("colValid_e14", 32'(colValid), 32'd1);
        checkEq("cols_e14", 32'(colObs), 32'(exp));
        checkEq("busy_e14", 32'(busy), 32'd0);
        tick();
        checkEq("colValid_e15", 32'(colValid), 32'd0);
        prevCols = exp;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        prevCols     = '0;
        resetN       = 1'b1;
        startOfFrame = 1'b0;
        setFar();
        tick();
        tick();
        resetN = 1'b0;
        checkEq("rst_cols", 32'(colObs), 32'd0);
        checkEq("rst_valid", 32'(colValid), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        tick();

`ifdef COL_APPROACH_ONLY_EN
        setFar();
        bx[0] = 100; by[0] = 100; bvx[0] = 5;
        bx[1] = 120; by[1] = 100;
        runFrame(10'b0000000001, 1'b0);
        bvx[0] = -5;
        runFrame(10'b0000000000, 1'b0);
`else
        setFar();
        bx[1] = 130; by[1] = 100;
        runFrame(10'b0000000001, 1'b0);
        bx[1] = 132; by[1] = 100;
        runFrame(10'b0000000000, 1'b0);
        bx[1] = 120; by[1] = 120;
        runFrame(10'b0000000001, 1'b0);
        setFar();
        bx[2] = 300; by[2] = 200;
        bx[3] = 300; by[3] = 200;
        act = 5'b10111;
        runFrame(10'b0000000000, 1'b0);
        act = 5'b11111;
        runFrame(10'b0010000000, 1'b0);

        // Abort: restart at edge 5 with col01 no longer overlapping.
        setFar();
        bx[1] = 130; by[1] = 100;
        runFrame(10'b0000000001, 1'b0);
        pulses = 0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (colValid) pulses++;
        end
        bx[1] = 700; by[1] = 700;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        if (colValid) pulses++;
        for (int e = 6; e <= 24; e++) begin
            tick();
            if (colValid) pulses++;
            if (e < 19) checkEq("abort_hold", 32'(colObs), 32'd1);
            if (e == 19) begin
                checkEq("abort_valid", 32'(colValid), 32'd1);
                checkEq("abort_cols", 32'(colObs), 32'd0);
            end
        end
        checkEq("abort_pulses", 32'(pulses), 32'd1);
        prevCols = '0;

        // Reset mid-scan at edge 7.
        setFar();
        bx[1] = 130; by[1] = 100;
        runFrame(10'b0000000001, 1'b0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
        checkEq("midrst_cols", 32'(colObs), 32'd0);
        checkEq("midrst_busy", 32'(busy), 32'd0);
        checkEq("midrst_valid", 32'(colValid), 32'd0);
        pulses = 0;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (colValid || busy) pulses++;
        end
        checkEq("midrst_idle", 32'(pulses), 32'd0);
        prevCols = '0;
`endif

        // Randomized frames: clustered (many hits) and spread (saturation).
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 5; i++) begin
                if (f % 3 != 2) begin
                    bx[i] = int'($urandom_range(0, 70));
                    by[i] = int'($urandom_range(0, 70));
                end else begin
                    bx[i] = int'($urandom_range(0, 20000)) - 10000;
                    by[i] = int'($urandom_range(0, 20000)) - 10000;
                end
                bvx[i] = int'($urandom_range(0, 20)) - 10;
                bvy[i] = int'($urandom_range(0, 20)) - 10;
            end
            act = 5'($urandom);
            if (f % 4 == 0) act = 5'b11111;
            expCols = modelCols();
            runFrame(expCols, f[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
